// File: rtl/prf_pkg.sv
// prf_pkg: default PRF parameters and shared register/data types
package prf_pkg;
  localparam int PRF_DATA_W = 16;
  localparam int PRF_NUM_PREG = 32;
  localparam int PRF_NUM_RD = 6;
  localparam int PRF_NUM_WR = 3;
  localparam int PRF_NUM_ALLOC = 2;
  localparam int PRF_PREG_W = $clog2(PRF_NUM_PREG);
  typedef logic [PRF_PREG_W-1:0] preg_t;
  typedef logic [PRF_DATA_W-1:0] prf_data_t;
endpackage

// File: rtl/prf_bypass_mux.sv
// prf_bypass_mux: forwards the highest-index same-cycle write matching a read port
module prf_bypass_mux import prf_pkg::*; #(
  parameter int DATA_W = PRF_DATA_W,
  parameter int PREG_W = PRF_PREG_W,
  parameter int NUM_WR = PRF_NUM_WR
) (
  input  logic [PREG_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     st_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*PREG_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_ready
);
  always_comb begin
    rd_data = st_data;
    rd_ready = st_ready;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k] && rd_addr != '0 && wr_addr[k*PREG_W +: PREG_W] == rd_addr) begin
        rd_data = wr_data[k*DATA_W +: DATA_W];
        rd_ready = 1'b1;
      end
  end
endmodule

// File: rtl/prf_multiport.sv
// prf_multiport: multiport physical register file with ready scoreboard; PRF_BYPASS_EN enables write-to-read bypass
module prf_multiport import prf_pkg::*; #(
  parameter int DATA_W = PRF_DATA_W,
  parameter int NUM_PREG = PRF_NUM_PREG,
  parameter int NUM_RD = PRF_NUM_RD,
  parameter int NUM_WR = PRF_NUM_WR,
  parameter int NUM_ALLOC = PRF_NUM_ALLOC,
  parameter int PREG_W = $clog2(NUM_PREG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
  output logic [NUM_RD*DATA_W-1:0]    rd_data,
  output logic [NUM_RD-1:0]           rd_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*PREG_W-1:0]    wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]    wr_data,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
  input  logic                        flush,
  output logic                        wr_conflict
);
  logic [DATA_W-1:0] data_q [NUM_PREG];
  logic [DATA_W-1:0] data_d [NUM_PREG];
  logic [NUM_PREG-1:0] ready_q, ready_d;
  logic wr_conflict_q, wr_conflict_d;
  logic [PREG_W-1:0] wa [NUM_WR];
  logic [PREG_W-1:0] aa [NUM_ALLOC];
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wa
    assign wa[k] = wr_addr[k*PREG_W +: PREG_W];
  end
  for (genvar j = 0; j < NUM_ALLOC; j++) begin : g_aa
    assign aa[j] = alloc_addr[j*PREG_W +: PREG_W];
  end
  // Register 0 is never targeted, so it keeps its reset value of 0 / ready
  always_comb begin
    data_d = data_q;
    ready_d = ready_q;
    wr_conflict_d = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && wa[k] != '0) begin
        data_d[wa[k]] = wr_data[k*DATA_W +: DATA_W];
        ready_d[wa[k]] = 1'b1;
      end
      for (int m = k + 1; m < NUM_WR; m++)
        wr_conflict_d = wr_conflict_d | (wr_en[k] && wr_en[m] && wa[k] != '0 && wa[k] == wa[m]);
    end
    for (int j = 0; j < NUM_ALLOC; j++)
      if (alloc_en[j] && aa[j] != '0) ready_d[aa[j]] = 1'b0;
    if (flush) ready_d = '1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PREG; i++) data_q[i] <= DATA_W'(i);
      ready_q <= '1;
      wr_conflict_q <= 1'b0;
    end else begin
      data_q <= data_d;
      ready_q <= ready_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end
  assign wr_conflict = wr_conflict_q;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [PREG_W-1:0] ra;
    assign ra = rd_addr[i*PREG_W +: PREG_W];
`ifdef PRF_BYPASS_EN
    prf_bypass_mux #(.DATA_W(DATA_W), .PREG_W(PREG_W), .NUM_WR(NUM_WR)) u_mux (
      .rd_addr(ra),
      .st_data(data_q[ra]),
      .st_ready(ready_q[ra]),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_data(rd_data[i*DATA_W +: DATA_W]),
      .rd_ready(rd_ready[i])
    );
`else
    assign rd_data[i*DATA_W +: DATA_W] = data_q[ra];
    assign rd_ready[i] = ready_q[ra];
`endif
  end
endmodule

// File: tb/tb_prf_multiport.sv
// tb_prf_multiport: scoreboard bench for prf_multiport with directed vectors
module tb_prf_multiport;
  localparam int DW = 16, NP = 32, NR = 6, NW = 3, NA = 2, PW = 5;
  logic clk = 1'b0, rst;
  logic [NR*PW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_ready;
  logic [NW-1:0] wr_en;
  logic [NW*PW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NA-1:0] alloc_en;
  logic [NA*PW-1:0] alloc_addr;
  logic flush, wr_conflict;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {
    int cyc;
    bit is_conf;
    int port;
    logic [DW-1:0] data;
    logic rdy;
    string name;
  } exp_t;
  exp_t sb[$];

  prf_multiport #(.DATA_W(DW), .NUM_PREG(NP), .NUM_RD(NR), .NUM_WR(NW), .NUM_ALLOC(NA)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .flush(flush), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (e.is_conf) begin
        if (wr_conflict !== e.rdy) begin
          n_fail++;
          $display("FAIL %s: wr_conflict=%b expected %b", e.name, wr_conflict, e.rdy);
        end
      end else if (rd_data[e.port*DW +: DW] !== e.data || rd_ready[e.port] !== e.rdy) begin
        n_fail++;
        $display("FAIL %s: rd_data=%h rd_ready=%b expected %h %b", e.name,
                 rd_data[e.port*DW +: DW], rd_ready[e.port], e.data, e.rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_en = '0;
    alloc_en = '0;
    flush = 1'b0;
  endtask
  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*PW +: PW] = PW'(a);
    wr_data[p*DW +: DW] = d;
  endtask
  task automatic al(input int p, input int a);
    alloc_en[p] = 1'b1;
    alloc_addr[p*PW +: PW] = PW'(a);
  endtask
  task automatic exp_rd(input int p, input int a, input logic [DW-1:0] d, input logic r, input string n);
    exp_t e;
    rd_addr[p*PW +: PW] = PW'(a);
    e.cyc = cyc; e.is_conf = 1'b0; e.port = p; e.data = d; e.rdy = r; e.name = n;
    sb.push_back(e);
  endtask
  task automatic exp_conf(input logic v, input string n);
    exp_t e;
    e.cyc = cyc; e.is_conf = 1'b1; e.port = 0; e.data = '0; e.rdy = v; e.name = n;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
    idle();
    tick(); tick();
    rst = 1'b1;
    tick();
    wr(0, 9, 16'h1111); wr(2, 9, 16'h2222); wr(1, 5, 16'hAAAA); al(0, 6);
    tick();
    idle();
    rst = 1'b0;
    exp_rd(0, 5, 16'd5, 1'b1, "rst_rd5");
    exp_rd(1, 0, 16'd0, 1'b1, "rst_rd0");
    exp_rd(2, 6, 16'd6, 1'b1, "rst_rd6");
    exp_rd(3, 9, 16'd9, 1'b1, "rst_rd9");
    exp_conf(1'b0, "rst_conf");
    tick();
    rst = 1'b1;
    tick();
    wr(1, 7, 16'hBEEF);
`ifdef PRF_BYPASS_EN
    exp_rd(0, 7, 16'hBEEF, 1'b1, "wr7_same");
`else
    exp_rd(0, 7, 16'd7, 1'b1, "wr7_same");
`endif
    tick();
    idle();
    exp_rd(0, 7, 16'hBEEF, 1'b1, "wr7_next");
    wr(0, 9, 16'h1111); wr(2, 9, 16'h2222);
    exp_conf(1'b0, "conf_before");
    tick();
    idle();
    exp_rd(1, 9, 16'h2222, 1'b1, "conf_data");
    exp_conf(1'b1, "conf_pulse");
    wr(0, 0, 16'h5555); wr(1, 0, 16'h6666);
    tick();
    idle();
    exp_conf(1'b0, "conf_end_r0");
    exp_rd(2, 0, 16'd0, 1'b1, "r0_unchanged");
    al(0, 12);
    tick();
    idle();
    exp_rd(0, 12, 16'd12, 1'b0, "alloc12");
    wr(0, 12, 16'h0042);
    tick();
    idle();
    exp_rd(0, 12, 16'h0042, 1'b1, "write12");
    al(1, 12); wr(2, 12, 16'h0077);
    tick();
    idle();
    exp_rd(0, 12, 16'h0077, 1'b0, "alloc_wr12");
    al(0, 3); al(1, 4);
    tick();
    idle();
    al(0, 5);
    tick();
    idle();
    exp_rd(0, 3, 16'd3, 1'b0, "pre_fl3");
    exp_rd(1, 4, 16'd4, 1'b0, "pre_fl4");
    exp_rd(2, 5, 16'd5, 1'b0, "pre_fl5");
    flush = 1'b1; al(0, 6); wr(0, 10, 16'h1234); wr(1, 10, 16'h4321);
    tick();
    idle();
    exp_rd(0, 3, 16'd3, 1'b1, "fl3");
    exp_rd(1, 4, 16'd4, 1'b1, "fl4");
    exp_rd(2, 5, 16'd5, 1'b1, "fl5");
    exp_rd(3, 6, 16'd6, 1'b1, "fl6");
    exp_rd(4, 10, 16'h4321, 1'b1, "fl_wr10");
    exp_rd(5, 12, 16'h0077, 1'b1, "fl12");
    exp_conf(1'b1, "fl_conf");
    tick();
    exp_conf(1'b0, "fl_conf_end");
    for (int t = 0; t < 20 && sb.size() > 0; t++) tick();
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
